// File: rtl/sdram_cpu_bridge_if.sv
// Signal bundle between the 8-bit CPU bus, the bridge and one 16-bit toggle-handshake
// SDRAM controller port. The bridge uses the slave modport; the CPU/controller side uses master.
interface sdram_cpu_bridge_if #(
  parameter int AW = 24
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_a;
  logic [7:0]    cpu_d;
  logic [7:0]    cpu_q;
  logic          cpu_ready;
  logic          cpu_done;
  logic          sd_req;
  logic          sd_ack;
  logic          sd_we;
  logic [AW-2:0] sd_a;
  logic [1:0]    sd_ds;
  logic [15:0]   sd_d;
  logic [15:0]   sd_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_a, cpu_d, sd_ack, sd_q,
    output cpu_q, cpu_ready, cpu_done, sd_req, sd_we, sd_a, sd_ds, sd_d
  );

  modport master (
    output cpu_req, cpu_we, cpu_a, cpu_d, sd_ack, sd_q,
    input  cpu_q, cpu_ready, cpu_done, sd_req, sd_we, sd_a, sd_ds, sd_d
  );
endinterface

// File: rtl/sdram_cpu_bridge.sv
// CPU byte bus to 16-bit SDRAM toggle port: one in-flight request plus a one-entry pending slot.
// Define SDRAM_BRIDGE_RCACHE_EN to add a one-word read cache with write-through.
module sdram_cpu_bridge #(
  parameter int AW = 24
) (
  input  logic              clk,
  input  logic              reset,
  sdram_cpu_bridge_if.slave bus
);
  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_sd_req;
  logic          r_sd_we;
  logic [AW-2:0] r_sd_a;
  logic [1:0]    r_sd_ds;
  logic [15:0]   r_sd_d;
  logic [7:0]    r_cpu_q;
  logic          r_cpu_done;

  logic          r_pend_vld;
  logic          r_pend_we;
  logic [AW-2:0] r_pend_a;
  logic [1:0]    r_pend_ds;
  logic [7:0]    r_pend_d;

  logic          w_ack;
  logic          w_ready;
  logic          w_sync;
  logic          w_issue_cpu;
  logic          w_issue_pend;
  logic          w_capture;
  logic          w_complete;
  logic          w_hit;
  logic          w_hit_take;
  logic [1:0]    w_cpu_ds;
  logic [7:0]    w_rd_byte;

  // The controller has finished once its ack toggle catches up with our request toggle
  assign w_ack     = (bus.sd_ack == r_sd_req);
  assign w_cpu_ds  = bus.cpu_a[0] ? 2'b10 : 2'b01;
  assign w_rd_byte = r_sd_ds[1] ? bus.sd_q[15:8] : bus.sd_q[7:0];

`ifdef SDRAM_BRIDGE_RCACHE_EN
  logic          r_c_vld;
  logic [AW-2:0] r_c_tag;
  logic [15:0]   r_c_data;

  assign w_hit = r_c_vld && !bus.cpu_we && (r_c_tag == bus.cpu_a[AW-1:1]);
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_SYNC;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC: w_state_nxt = S_IDLE;
      S_IDLE: if (bus.cpu_req && !w_hit) w_state_nxt = S_BUSY;
      S_BUSY: if (w_ack && !r_pend_vld && !bus.cpu_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_SYNC;
    endcase
  end

  always_comb begin
    w_ready      = 1'b0;
    w_sync       = 1'b0;
    w_issue_cpu  = 1'b0;
    w_issue_pend = 1'b0;
    w_capture    = 1'b0;
    w_complete   = 1'b0;
    w_hit_take   = 1'b0;
    case (r_state)
      S_SYNC: w_sync = 1'b1;
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.cpu_req) begin
          if (w_hit) w_hit_take  = 1'b1;
          else       w_issue_cpu = 1'b1;
        end
      end
      S_BUSY: begin
        w_ready = !r_pend_vld;
        if (w_ack) begin
          w_complete = 1'b1;
          // Pending strobe is older than anything arriving now, so it goes first
          if (r_pend_vld)       w_issue_pend = 1'b1;
          else if (bus.cpu_req) w_issue_cpu  = 1'b1;
        end else if (bus.cpu_req && !r_pend_vld) begin
          w_capture = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sd_req   <= 1'b0;
      r_sd_we    <= 1'b0;
      r_sd_a     <= '0;
      r_sd_ds    <= 2'b00;
      r_sd_d     <= 16'h0000;
      r_cpu_q    <= 8'h00;
      r_cpu_done <= 1'b0;
      r_pend_vld <= 1'b0;
    end else begin
      r_cpu_done <= w_complete | w_hit_take;

      if (w_sync)                          r_sd_req <= bus.sd_ack;
      else if (w_issue_cpu || w_issue_pend) r_sd_req <= ~r_sd_req;

      if (w_issue_pend) begin
        r_sd_we <= r_pend_we;
        r_sd_a  <= r_pend_a;
        r_sd_ds <= r_pend_ds;
        r_sd_d  <= {r_pend_d, r_pend_d};
      end else if (w_issue_cpu) begin
        r_sd_we <= bus.cpu_we;
        r_sd_a  <= bus.cpu_a[AW-1:1];
        r_sd_ds <= w_cpu_ds;
        r_sd_d  <= {bus.cpu_d, bus.cpu_d};
      end

      if (w_capture)                   r_pend_vld <= 1'b1;
      else if (w_issue_pend || w_sync) r_pend_vld <= 1'b0;

      if (w_complete && !r_sd_we) r_cpu_q <= w_rd_byte;
`ifdef SDRAM_BRIDGE_RCACHE_EN
      else if (w_hit_take)        r_cpu_q <= bus.cpu_a[0] ? r_c_data[15:8] : r_c_data[7:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_pend_we <= bus.cpu_we;
      r_pend_a  <= bus.cpu_a[AW-1:1];
      r_pend_ds <= w_cpu_ds;
      r_pend_d  <= bus.cpu_d;
    end
  end

`ifdef SDRAM_BRIDGE_RCACHE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_c_vld <= 1'b0;
    else if (w_sync)                  r_c_vld <= 1'b0;
    else if (w_complete && !r_sd_we)  r_c_vld <= 1'b1;
  end

  // Reads refill the whole word; writes only patch a word already held
  always_ff @(posedge clk) begin
    if (w_complete) begin
      if (!r_sd_we) begin
        r_c_tag  <= r_sd_a;
        r_c_data <= bus.sd_q;
      end else if (r_c_vld && (r_c_tag == r_sd_a)) begin
        if (r_sd_ds[0]) r_c_data[7:0]  <= r_sd_d[7:0];
        if (r_sd_ds[1]) r_c_data[15:8] <= r_sd_d[15:8];
      end
    end
  end
`endif

  assign bus.sd_req    = r_sd_req;
  assign bus.sd_we     = r_sd_we;
  assign bus.sd_a      = r_sd_a;
  assign bus.sd_ds     = r_sd_ds;
  assign bus.sd_d      = r_sd_d;
  assign bus.cpu_q     = r_cpu_q;
  assign bus.cpu_done  = r_cpu_done;
  assign bus.cpu_ready = w_ready;
endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Directed plus randomized bench for sdram_cpu_bridge with a behavioural SDRAM responder
// and a byte-addressed reference memory; honours SDRAM_BRIDGE_RCACHE_EN.
`timescale 1ns/1ps
module tb_sdram_cpu_bridge;
  localparam int AW = 24;

  typedef struct {
    logic          we;
    logic [1:0]    ds;
    logic [15:0]   d;
    logic [AW-2:0] a;
  } iss_t;

  typedef struct {
    bit         rd;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_cpu_bridge_if #(.AW(AW)) bif ();
  sdram_cpu_bridge #(.AW(AW)) dut (.clk(clk), .reset(reset), .bus(bif));

  int n_checks = 0;
  int n_pass   = 0;

  // responder controls (written by the stimulus only)
  bit   ctl_en    = 1'b0;
  int   ack_delay = 1;
  int   ack_req_n = 0;
  logic ack_val   = 1'b0;

  // monitor results (written by the monitor only)
  int         tgl_cnt  = 0;
  int         done_cnt = 0;
  iss_t       iss_q[$];
  logic [7:0] got_q[$];

  logic [7:0] ref_mem [int];
  exp_t       exp_q[$];

  // SDRAM controller model: acts on the falling edge, ack after ack_delay cycles
  initial begin
    logic [15:0] ctl_mem [int];
    logic [15:0] w;
    int          cnt;
    int          ack_done_n;
    cnt = 0;
    ack_done_n = 0;
    ctl_mem[24'h00091A] = 16'hA55A;
    ctl_mem[24'h000100] = 16'h5BE1;
    bif.sd_ack = 1'b1;
    bif.sd_q   = 16'h0000;
    forever begin
      @(negedge clk);
      if (ack_done_n != ack_req_n) begin
        bif.sd_ack = ack_val;
        ack_done_n = ack_req_n;
      end
      if (ctl_en && !reset && (bif.sd_req !== bif.sd_ack)) begin
        cnt++;
        if (cnt >= ack_delay) begin
          cnt = 0;
          w = ctl_mem.exists(int'(bif.sd_a)) ? ctl_mem[int'(bif.sd_a)] : 16'h0000;
          if (bif.sd_we) begin
            if (bif.sd_ds[0]) w[7:0]  = bif.sd_d[7:0];
            if (bif.sd_ds[1]) w[15:8] = bif.sd_d[15:8];
            ctl_mem[int'(bif.sd_a)] = w;
          end else begin
            bif.sd_q = w;
          end
          bif.sd_ack = bif.sd_req;
        end
      end
    end
  end

  // Monitor: counts request toggles (with the fields issued) and done pulses
  initial begin
    logic prev_req;
    iss_t e;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && (bif.sd_req !== prev_req)) begin
        tgl_cnt++;
        e.we = bif.sd_we; e.ds = bif.sd_ds; e.d = bif.sd_d; e.a = bif.sd_a;
        iss_q.push_back(e);
      end
      prev_req = bif.sd_req;
      if (bif.cpu_done === 1'b1) begin
        done_cnt++;
        got_q.push_back(bif.cpu_q);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d passed of %0d)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  function automatic iss_t iss_at(input int i);
    iss_t z;
    z.we = 1'bx; z.ds = 2'bxx; z.d = 'x; z.a = 'x;
    return (i < iss_q.size()) ? iss_q[i] : z;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  task automatic drive(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    bif.cpu_req = 1'b1;
    bif.cpu_we  = we;
    bif.cpu_a   = a;
    bif.cpu_d   = d;
    @(negedge clk);
    bif.cpu_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done_cnt, target);
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int k;
    k = 0;
    while (bif.cpu_ready !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, bif.cpu_ready, 1'b1);
  endtask

  initial begin
    int   tb0, ib, db, n_rnd;
    logic stale;
    iss_t e;
    bif.cpu_req = 1'b0;
    bif.cpu_we  = 1'b0;
    bif.cpu_a   = '0;
    bif.cpu_d   = 8'h00;
    ref_mem[24'h001235] = 8'hA5;
    ref_mem[24'h001234] = 8'h5A;
    ref_mem[24'h000200] = 8'hE1;
    ref_mem[24'h000201] = 8'h5B;

    // reset values, then one SYNC cycle adopting sd_ack=1
    repeat (3) @(negedge clk);
    check("rst_ready", bif.cpu_ready, 1'b0);
    check("rst_sd_req", bif.sd_req, 1'b0);
    check("rst_done", bif.cpu_done, 1'b0);
    check("rst_sd_ds", bif.sd_ds, 2'b00);
    check("rst_cpu_q", bif.cpu_q, 8'h00);
    reset = 1'b0;
    #1;
    check("sync_ready_low", bif.cpu_ready, 1'b0);
    @(negedge clk);
    check("sync_sd_req", bif.sd_req, 1'b1);
    check("sync_ready_high", bif.cpu_ready, 1'b1);
    tb0 = tgl_cnt;
    repeat (3) @(negedge clk);
    check("sync_no_toggle", tgl_cnt - tb0, 0);
    ctl_en = 1'b1;

    // single read with 6-cycle ack
    ack_delay = 6;
    tb0 = tgl_cnt; ib = iss_q.size(); db = done_cnt;
    drive(1'b0, 24'h001235, 8'h00);
    wait_done(db + 1, 50, "rd_done");
    e = iss_at(ib);
    check("rd_sd_a", e.a, 23'h00091A);
    check("rd_sd_ds", e.ds, 2'b10);
    check("rd_sd_we", e.we, 1'b0);
    check("rd_cpu_q", got_at(db), ref_rd(24'h001235));
    repeat (3) @(negedge clk);
    check("rd_one_pulse", done_cnt - db, 1);
    check("rd_one_toggle", tgl_cnt - tb0, 1);

    // write at minimum latency
    ack_delay = 1;
    tb0 = tgl_cnt; ib = iss_q.size(); db = done_cnt;
    drive(1'b1, 24'h000010, 8'h3C);
    ref_mem[24'h000010] = 8'h3C;
    @(negedge clk);
    check("wr_min_latency_done", bif.cpu_done, 1'b1);
    e = iss_at(ib);
    check("wr_sd_we", e.we, 1'b1);
    check("wr_sd_ds", e.ds, 2'b01);
    check("wr_sd_d", e.d, 16'h3C3C);
    check("wr_sd_a", e.a, 23'h000008);
    repeat (2) @(negedge clk);
    check("wr_one_toggle", tgl_cnt - tb0, 1);
    check("wr_one_pulse", done_cnt - db, 1);

    // write + read back to back on a slow ack; third strobe must be dropped
    ack_delay = 10;
    tb0 = tgl_cnt; ib = iss_q.size(); db = done_cnt;
    drive(1'b1, 24'h000020, 8'hC4);
    ref_mem[24'h000020] = 8'hC4;
    drive(1'b0, 24'h000010, 8'h00);
    check("pend_ready_low", bif.cpu_ready, 1'b0);
    drive(1'b1, 24'h000030, 8'h99);
    wait_done(db + 2, 100, "pend_done");
    repeat (20) @(negedge clk);
    check("pend_two_toggles", tgl_cnt - tb0, 2);
    check("pend_two_pulses", done_cnt - db, 2);
    e = iss_at(ib);
    check("pend_first_we", e.we, 1'b1);
    check("pend_first_a", e.a, 23'h000010);
    e = iss_at(ib + 1);
    check("pend_second_we", e.we, 1'b0);
    check("pend_second_a", e.a, 23'h000008);
    check("pend_read_q", got_at(db + 1), ref_rd(24'h000010));
    check("pend_ready_back", bif.cpu_ready, 1'b1);

    // reset while busy, stale ack arrives during reset
    ctl_en = 1'b0;
    drive(1'b0, 24'h000040, 8'h00);
    repeat (2) @(negedge clk);
    stale = bif.sd_req;
    db = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    ack_val = stale;
    ack_req_n++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy_realign", bif.sd_req, bif.sd_ack);
    check("rst_busy_no_done", done_cnt - db, 0);
    ctl_en = 1'b1;
    ack_delay = 3;
    tb0 = tgl_cnt; db = done_cnt;
    drive(1'b0, 24'h001235, 8'h00);
    wait_done(db + 1, 50, "rst_busy_next_done");
    check("rst_busy_next_q", got_at(db), ref_rd(24'h001235));
    check("rst_busy_next_toggle", tgl_cnt - tb0, 1);

    // the dropped strobe must not have written memory
    db = done_cnt;
    wait_ready(50, "drop_ready");
    drive(1'b0, 24'h000030, 8'h00);
    wait_done(db + 1, 50, "drop_done");
    check("drop_read_q", got_at(db), ref_rd(24'h000030));

    // randomized program-order traffic
    n_rnd = 40;
    tb0 = tgl_cnt; db = done_cnt;
    exp_q.delete();
    for (int i = 0; i < n_rnd; i++) begin
      logic          we;
      logic [AW-1:0] a;
      logic [7:0]    d;
      exp_t          x;
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 31));
      d  = 8'($urandom);
      ack_delay = $urandom_range(1, 4);
      wait_ready(100, "rnd_ready");
      x.rd = !we;
      x.v  = we ? 8'h00 : ref_rd(a);
      if (we) ref_mem[int'(a)] = d;
      exp_q.push_back(x);
      drive(we, a, d);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    wait_done(db + n_rnd, 3000, "rnd_done");
    for (int i = 0; i < n_rnd; i++) begin
      if (exp_q[i].rd) check($sformatf("rnd_rd%0d", i), got_at(db + i), exp_q[i].v);
    end
`ifdef SDRAM_BRIDGE_RCACHE_EN
    check("rnd_toggles_bound", (tgl_cnt - tb0) <= n_rnd, 1'b1);
`else
    check("rnd_toggles", tgl_cnt - tb0, n_rnd);
`endif

    // read cache sequence
    ack_delay = 2;
    repeat (3) @(negedge clk);
    tb0 = tgl_cnt; db = done_cnt;
    wait_ready(50, "c_ready1");
    drive(1'b0, 24'h000200, 8'h00);
    wait_done(db + 1, 50, "c_rd1_done");
    check("c_rd1_q", got_at(db), ref_rd(24'h000200));
    check("c_rd1_toggle", tgl_cnt - tb0, 1);
    repeat (2) @(negedge clk);
    tb0 = tgl_cnt; db = done_cnt;
    drive(1'b0, 24'h000200, 8'h00);
`ifdef SDRAM_BRIDGE_RCACHE_EN
    check("c_rd2_done_next", bif.cpu_done, 1'b1);
    check("c_rd2_no_toggle", tgl_cnt - tb0, 0);
`else
    wait_done(db + 1, 50, "c_rd2_done");
    check("c_rd2_toggle", tgl_cnt - tb0, 1);
`endif
    check("c_rd2_q", got_at(db), ref_rd(24'h000200));
    repeat (2) @(negedge clk);
    db = done_cnt;
    wait_ready(50, "c_ready3");
    drive(1'b1, 24'h000201, 8'h77);
    ref_mem[24'h000201] = 8'h77;
    wait_done(db + 1, 50, "c_wr_done");
    repeat (2) @(negedge clk);
    tb0 = tgl_cnt; db = done_cnt;
    drive(1'b0, 24'h000201, 8'h00);
`ifdef SDRAM_BRIDGE_RCACHE_EN
    check("c_rd3_done_next", bif.cpu_done, 1'b1);
    check("c_rd3_no_toggle", tgl_cnt - tb0, 0);
`else
    wait_done(db + 1, 50, "c_rd3_done");
    check("c_rd3_toggle", tgl_cnt - tb0, 1);
`endif
    check("c_rd3_q", got_at(db), 8'h77);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sdram_cpu_bridge.md
Name: sdram_cpu_bridge

Overview:
- Upstream adapter between the 8-bit CPU/chipset bus and one 16-bit toggle-handshake port of the SDRAM controller.
- Converts single-cycle byte access strobes into word requests with byte masks. Holds one in-flight request plus a one-entry pending slot, and returns read bytes with a done pulse.
- Strict program order is kept across reads and writes.

Parameters:
- AW, 24: CPU byte address width; SDRAM word address is AW-1 bits.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  one-cycle access strobe; only honoured while cpu_ready=1
- cpu_we  in  1  1=write, 0=read
- cpu_a  in  AW  byte address
- cpu_d  in  8  write byte
- cpu_q  out  8  read byte; valid when cpu_done pulses for a read
- cpu_ready  out  1  bridge can accept a strobe this cycle
- cpu_done  out  1  one-cycle pulse when an access completes (read or write)
- sd_req  out  1  toggle request
- sd_ack  in  1  toggle acknowledge; the access is complete when sd_ack==sd_req
- sd_we  out  1  write enable for the request
- sd_a  out  AW-1  word address = cpu_a[AW-1:1]
- sd_ds  out  2  byte enables: cpu_a[0]=0 -> 2'b01 (low byte), 1 -> 2'b10 (high byte)
- sd_d  out  16  write data = {cpu_d, cpu_d}
- sd_q  in  16  read word from the controller

Behaviour:
- Reset (async) values:
  - state=SYNC, sd_req=0, sd_we=0, sd_a=0, sd_ds=0, sd_d=0.
  - cpu_q=0, cpu_done=0, cpu_ready=0.
  - pending empty, cache invalid.
- State machine:
  - SYNC: lasts one cycle. Sets sd_req<=sd_ack, so the controller's toggle state is adopted and no request is launched. Then goes to IDLE.
  - IDLE: cpu_ready=1. On cpu_req, register sd_we/sd_a/sd_ds/sd_d, toggle sd_req at the same edge, and go to BUSY.
  - BUSY: waits for sd_ack==sd_req (sampled on the registered sd_req).
    - cpu_req arriving with pending empty: the strobe is captured into pending and cpu_ready drops the next cycle.
- Completion edge (BUSY and sd_ack==sd_req):
  - Next cycle: cpu_done=1. For a read, cpu_q = sd_ds[1] ? sd_q[15:8] : sd_q[7:0], using sd_q sampled at the completion edge.
  - If pending is full: issue pending at that same edge (toggle sd_req, load sd_* fields), empty the slot, stay in BUSY, and raise cpu_ready the next cycle.
  - Otherwise, if cpu_req is present at that edge: issue it directly and stay in BUSY.
  - Otherwise go to IDLE.
- cpu_ready = 1 in IDLE, and in BUSY while pending is empty. cpu_ready = 0 in SYNC and when pending is full.
- cpu_req while cpu_ready=0 is ignored: no side effects, no pulse.
- Minimum latency: strobe at edge N -> sd_req toggles at N -> ack seen at edge M -> cpu_done high in cycle M+1.
- sd_* outputs are stable from issue until completion.
- Ordering: the pending access always issues after the outstanding one; completion order equals issue order.
- Reset mid-operation: the outstanding and pending accesses are abandoned with no cpu_done pulse. SYNC then re-aligns sd_req to sd_ack. An ack for the abandoned access that arrives later is absorbed because SYNC adopts the current sd_ack.

Optional Feature:
- Macro: SDRAM_BRIDGE_RCACHE_EN.
- Enabled: one-word read cache (word tag AW-1 bits, 16-bit data, valid bit).
  - Fill: every read completion writes tag+data and sets valid.
  - Write-through: at write completion, if the tag matches, the enabled byte is updated in the cache. The write still goes to SDRAM.
  - Hit: a read strobe accepted in IDLE whose word address matches a valid tag is served without an SDRAM access. sd_req does not toggle; cpu_q and cpu_done appear in the next cycle; state stays IDLE.
  - Reads accepted in BUSY never hit.
  - reset/SYNC invalidates the cache.
- Disabled: every read goes to SDRAM; no cache registers exist.

Test Plan:
- Reset release with sd_ack held 1 -> one cycle cpu_ready=0, then sd_req=1 and no toggle; cpu_ready=1.
- Read 0x001235, controller acks 6 cycles later with sd_q=16'hA55A -> sd_a=0x00091A, sd_ds=2'b10; cpu_done pulses once; cpu_q=8'hA5.
- Write 0x000010 data 8'h3C -> sd_we=1, sd_ds=2'b01, sd_d=16'h3C3C; one sd_req toggle; cpu_done after ack.
- Write then read strobes back to back with a slow ack:
  - Expected: read captured into pending; cpu_ready low; read issued at the write's completion edge; two cpu_done pulses in order.
  - Third strobe while pending is full -> ignored, with no extra toggle.
- Assert reset while BUSY, then deliver the stale ack -> no cpu_done; after SYNC, sd_req==sd_ack and the next read issues normally.
- SDRAM_BRIDGE_RCACHE_EN: read 0x0200 twice, then write 0x0201=8'h77, then read 0x0201.
  - Second read: no sd_req toggle; cpu_done the next cycle.
  - Final read: hit returning 8'h77.
